// File: rtl/wm_sequencer_if.sv
// -----------------------------------------------------------------------------
// wm_sequencer_if
// Bundle of handshake and actuator signals between the washing-machine
// sequencer and its environment.
//   slave  modport : sequencer side. It takes user controls and timer
//                    responses as inputs, and drives the phase code,
//                    actuators and status.
//   master modport : environment side, with the directions reversed.
// Clock and reset are not part of the bundle.
// -----------------------------------------------------------------------------
interface wm_sequencer_if;
    // user controls / sensors
    logic       start;
    logic       pause;
    logic       cancel;
    logic       door_closed;
    // phase timer responses
    logic       sig_Full;
    logic       sig_Temperature;
    logic       sig_Completed;
    // phase code to the timer
    logic [2:0] state;
    // actuators and status
    logic       water_valve;
    logic       heater;
    logic       motor_wash;
    logic       motor_spin;
    logic       drain_pump;
    logic       door_lock;
    logic       done;
    logic       fault;

    modport slave (
        input  start, pause, cancel, door_closed,
        input  sig_Full, sig_Temperature, sig_Completed,
        output state, water_valve, heater, motor_wash, motor_spin,
        output drain_pump, door_lock, done, fault
    );

    modport master (
        output start, pause, cancel, door_closed,
        output sig_Full, sig_Temperature, sig_Completed,
        input  state, water_valve, heater, motor_wash, motor_spin,
        input  drain_pump, door_lock, done, fault
    );
endinterface

// File: rtl/wm_sequencer.sv
// -----------------------------------------------------------------------------
// wm_sequencer
// Washing-machine phase controller. It steps through the phases
// IDLE, FILL, HEAT, WASH, DRAIN, SPIN and DONE on the responses of the phase
// timer. It also provides:
//   - rinse passes
//   - a per-phase watchdog
//   - pause
//   - cancel, which aborts the program through DRAIN
//   - a door-open fault
// Ports:
//   clock : rising-edge system clock
//   reset : synchronous, active-high reset
//   bus   : wm_sequencer_if.slave
//           inputs : start, pause, cancel, door_closed, sig_*
//           outputs: state, actuators, door_lock, done, fault
// All outputs are registered. An input sampled at an edge shows up in the
// outputs right after that edge.
// -----------------------------------------------------------------------------
module wm_sequencer #(
    parameter int unsigned RINSE_CYCLES = 1,
    parameter int unsigned TIMEOUT      = 1000,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            clock,
    input  logic            reset,
    wm_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_HEAT  = 3'd2,
        ST_WASH  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6,
        ST_FAULT = 3'd7
    } state_e;

    // The watchdog fires when the count reaches this value with no exit present.
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       RINSE_LAST = 3'(RINSE_CYCLES);

    state_e           state_q, state_d;
    logic [2:0]       rinse_q, rinse_d;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             cancel_pending_q, cancel_pending_d;

    logic             exit_s;      // the current phase's completion response is present
    logic             pend_eff_s;  // a cancel is pending or is arriving this cycle
    logic             paused_s;    // the phase is held by pause at this edge

    logic             water_valve_q, heater_q, motor_wash_q, motor_spin_q;
    logic             drain_pump_q, door_lock_q, done_q, fault_q;

    // Returns 1 for the phases that run machinery and are watched by the watchdog.
    function automatic logic is_active(input state_e s);
        return (s == ST_FILL) || (s == ST_HEAT) || (s == ST_WASH) ||
               (s == ST_DRAIN) || (s == ST_SPIN);
    endfunction

    // Next-state logic for the phase, rinse count, watchdog and cancel bookkeeping.
    always_comb begin
        state_d          = state_q;
        rinse_d          = rinse_q;
        wdog_d           = wdog_q;
        cancel_pending_d = cancel_pending_q;
        paused_s         = 1'b0;
        exit_s           = 1'b0;
        pend_eff_s       = cancel_pending_q | bus.cancel;

        // Each phase listens only to its own timer response.
        case (state_q)
            ST_FILL:                    exit_s = bus.sig_Full;
            ST_HEAT:                    exit_s = bus.sig_Temperature;
            ST_WASH, ST_DRAIN, ST_SPIN: exit_s = bus.sig_Completed;
            default:                    exit_s = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (bus.start && bus.door_closed) begin
                    state_d = ST_FILL;
                    rinse_d = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DONE: begin
                wdog_d  = '0;
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                wdog_d  = '0;
                state_d = ST_FAULT;
            end

            default: begin
                if (!bus.door_closed) begin
                    state_d          = ST_FAULT;
                    cancel_pending_d = 1'b0;
                end else if (bus.cancel && (state_q != ST_DRAIN)) begin
                    state_d          = ST_DRAIN;
                    cancel_pending_d = 1'b1;
                end else begin
                    // Inside DRAIN a cancel only latches the pending flag.
                    // The drain keeps running, so the watchdog and the
                    // exit still apply.
                    if (bus.cancel) begin
                        cancel_pending_d = 1'b1;
                    end else begin
                        cancel_pending_d = cancel_pending_q;
                    end

                    if (bus.pause) begin
                        paused_s = 1'b1;
                    end else if (exit_s) begin
                        case (state_q)
                            ST_FILL:  state_d = (rinse_q == 3'd0) ? ST_HEAT : ST_WASH;
                            ST_HEAT:  state_d = ST_WASH;
                            ST_WASH:  state_d = ST_DRAIN;
                            ST_DRAIN: begin
                                if (pend_eff_s) begin
                                    state_d          = ST_IDLE;
                                    cancel_pending_d = 1'b0;
                                end else if (rinse_q < RINSE_LAST) begin
                                    state_d = ST_FILL;
                                    rinse_d = rinse_q + 3'd1;
                                end else begin
                                    state_d = ST_SPIN;
                                end
                            end
                            ST_SPIN:  state_d = ST_DONE;
                            default:  state_d = ST_FAULT;
                        endcase
                    end else if (wdog_q == WDOG_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = state_q;
                    end
                end

                // The watchdog restarts on any phase change and is frozen while paused.
                if (state_d != state_q) begin
                    wdog_d = '0;
                end else if (paused_s) begin
                    wdog_d = wdog_q;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Phase register plus registered output decode of the upcoming phase.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            rinse_q          <= 3'd0;
            wdog_q           <= '0;
            cancel_pending_q <= 1'b0;
            water_valve_q    <= 1'b0;
            heater_q         <= 1'b0;
            motor_wash_q     <= 1'b0;
            motor_spin_q     <= 1'b0;
            drain_pump_q     <= 1'b0;
            door_lock_q      <= 1'b0;
            done_q           <= 1'b0;
            fault_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            rinse_q          <= rinse_d;
            wdog_q           <= wdog_d;
            cancel_pending_q <= cancel_pending_d;
            water_valve_q    <= (state_d == ST_FILL) && !paused_s;
            heater_q         <= (state_d == ST_HEAT) && !paused_s;
            motor_wash_q     <= (state_d == ST_WASH) && !paused_s;
            motor_spin_q     <= (state_d == ST_SPIN) && !paused_s;
            drain_pump_q     <= ((state_d == ST_DRAIN) || (state_d == ST_SPIN)) && !paused_s;
            door_lock_q      <= is_active(state_d) || (state_d == ST_FAULT);
            done_q           <= (state_d == ST_DONE);
            fault_q          <= (state_d == ST_FAULT);
        end
    end

    assign bus.state       = state_q;
    assign bus.water_valve = water_valve_q;
    assign bus.heater      = heater_q;
    assign bus.motor_wash  = motor_wash_q;
    assign bus.motor_spin  = motor_spin_q;
    assign bus.drain_pump  = drain_pump_q;
    assign bus.door_lock   = door_lock_q;
    assign bus.done        = done_q;
    assign bus.fault       = fault_q;

endmodule
